// File: rtl/ccd_data_serializer.sv
`default_nettype none
// ============================================================================
// Module   : ccd_data_serializer
// Purpose  : 16-bit pixel stream to two MSB-first serial lanes with frame
//            clock, SAV/EAV line markers and bitslip training during blanking.
// Revision : 1.0 - initial release
// ============================================================================
module ccd_data_serializer #(
    parameter logic [15:0] TRAIN_WORD = 16'hF0F0,
    parameter logic [15:0] SAV_WORD   = 16'hFF00,
    parameter logic [15:0] EAV_WORD   = 16'hFF80,
    parameter logic [15:0] PIX_MAX    = 16'hFEFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_vref,
    input  logic        i_href,
    input  logic [15:0] iv_data,
    output logic        o_ready,
    output logic [1:0]  ov_lane,
    output logic        o_frame_clk,
    output logic        o_sync
);

    logic [2:0]  r_cnt;
    logic        r_ready;
    logic [15:0] r_sreg;
    logic        r_sync;
    logic        r_pend_act;   // word waiting one slot before transmission
    logic [15:0] r_pend_data;
    logic        r_tx_act;     // activity of the word currently on the lanes

    logic        w_boundary;
    logic        w_in_act;
    logic [15:0] w_enc_word;
    logic        w_enc_sync;

    assign w_boundary = (r_cnt == 3'd7);
    assign w_in_act   = i_vref & i_href;

    // Look-around encoder: pending word, with the freshly sampled word as
    // lookahead and the outgoing word as history.
    always_comb begin
        w_enc_word = TRAIN_WORD;
        w_enc_sync = 1'b0;
        if (r_pend_act) begin
            w_enc_word = (r_pend_data > PIX_MAX) ? PIX_MAX : r_pend_data;
        end else if (w_in_act) begin
            w_enc_word = SAV_WORD;
            w_enc_sync = 1'b1;
        end else if (r_tx_act) begin
            w_enc_word = EAV_WORD;
            w_enc_sync = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= 3'd0;
            r_ready     <= 1'b0;
            r_sreg      <= TRAIN_WORD;
            r_sync      <= 1'b0;
            r_pend_act  <= 1'b0;
            r_pend_data <= 16'h0000;
            r_tx_act    <= 1'b0;
        end else begin
            r_cnt   <= r_cnt + 3'd1;
            r_ready <= (r_cnt == 3'd6);
            if (w_boundary) begin
                r_sreg      <= w_enc_word;
                r_sync      <= w_enc_sync;
                r_tx_act    <= r_pend_act;
                r_pend_act  <= w_in_act;
                r_pend_data <= iv_data;
            end else begin
                r_sreg <= {r_sreg[14:8], 1'b0, r_sreg[6:0], 1'b0};
            end
        end
    end

    assign o_ready     = r_ready;
    assign ov_lane     = {r_sreg[15], r_sreg[7]};
    assign o_frame_clk = ~r_cnt[2];
    assign o_sync      = r_sync;

endmodule
`default_nettype wire

// File: tb/tb_ccd_data_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ccd_data_serializer
// Purpose  : Self-checking bench for ccd_data_serializer: word-history model,
//            framing table, mid-word reset sequence and random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ccd_data_serializer;

    localparam logic [15:0] C_TRAIN = 16'hF0F0;
    localparam logic [15:0] C_SAV   = 16'hFF00;
    localparam logic [15:0] C_EAV   = 16'hFF80;
    localparam logic [15:0] C_PMAX  = 16'hFEFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_vref = 1'b0;
    logic        i_href = 1'b0;
    logic [15:0] iv_data = 16'h0000;
    logic        o_ready;
    logic [1:0]  ov_lane;
    logic        o_frame_clk;
    logic        o_sync;

    int vectors = 0;
    int miscompares = 0;

    ccd_data_serializer dut (
        .clk         (clk),
        .reset       (reset),
        .i_vref      (i_vref),
        .i_href      (i_href),
        .iv_data     (iv_data),
        .o_ready     (o_ready),
        .ov_lane     (ov_lane),
        .o_frame_clk (o_frame_clk),
        .o_sync      (o_sync)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        act;
        logic [15:0] data;
    } samp_t;

    typedef struct {
        logic        v;
        logic        h;
        logic [15:0] d;
        logic [15:0] exp;
        logic        es;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transmitted word from the sampled-word history: {sync, word}.
    function automatic logic [16:0] model_word(input samp_t prev, input samp_t cur, input samp_t nxt);
        if (cur.act)  return {1'b0, (cur.data > C_PMAX) ? C_PMAX : cur.data};
        if (nxt.act)  return {1'b1, C_SAV};
        if (prev.act) return {1'b1, C_EAV};
        return {1'b0, C_TRAIN};
    endfunction

    samp_t       hist[$];
    samp_t       m_s;
    int          m_slot = 0;
    logic [15:0] m_word = C_TRAIN;
    logic        m_sync = 1'b0;
    bit          m_valid = 1'b0;
    logic [7:0]  rx_hi, rx_lo;
    logic [16:0] rx_q[$];

    always @(posedge clk) begin
        if (reset) begin
            m_slot = 0;
            m_word = C_TRAIN;
            m_sync = 1'b0;
            hist.delete();
            m_s.act = 1'b0;
            m_s.data = 16'h0000;
            hist.push_back(m_s);
            hist.push_back(m_s);
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_slot == 7) begin
                m_s.act  = i_vref & i_href;
                m_s.data = iv_data;
                hist.push_back(m_s);
                {m_sync, m_word} = model_word(hist[0], hist[1], hist[2]);
                void'(hist.pop_front());
                m_slot = 0;
            end else begin
                m_slot++;
            end
        end
        #1;
        if (m_valid) begin
            check("cycle{lane1,lane0,fclk,ready,sync}",
                  {27'd0, ov_lane, o_frame_clk, o_ready, o_sync},
                  {27'd0, m_word[15-m_slot], m_word[7-m_slot], (m_slot < 4), (m_slot == 7), m_sync});
            rx_hi[7-m_slot] = ov_lane[1];
            rx_lo[7-m_slot] = ov_lane[0];
            if (m_slot == 7) rx_q.push_back({o_sync, rx_hi, rx_lo});
        end
    end

    // One word period, starting and ending at the negedge after a boundary.
    task automatic send_word(input logic v, input logic h, input logic [15:0] d, input bit glitch);
        i_vref = v; i_href = h; iv_data = d;
        if (glitch) begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            i_href = ~h; iv_data = ~d;
            @(posedge clk);
            @(negedge clk);
            i_href = h; iv_data = d;
            repeat (4) @(posedge clk);
        end else begin
            repeat (8) @(posedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        vec_t tbl[18];
        int   base;
        logic fv;

        tbl[0]  = '{1'b1, 1'b0, 16'h0000, C_SAV,   1'b1};
        tbl[1]  = '{1'b1, 1'b1, 16'h0123, 16'h0123, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 16'h4567, 16'h4567, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 16'h89AB, 16'h89AB, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 16'hCDEF, 16'hCDEF, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 16'h0000, C_EAV,   1'b1};
        tbl[6]  = '{1'b1, 1'b0, 16'h0000, C_TRAIN, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 16'h0000, C_SAV,   1'b1};
        tbl[8]  = '{1'b1, 1'b1, 16'hFFFF, C_PMAX,  1'b0};
        tbl[9]  = '{1'b1, 1'b1, 16'hFF00, C_PMAX,  1'b0};
        tbl[10] = '{1'b1, 1'b0, 16'h0000, C_SAV,   1'b1};
        tbl[11] = '{1'b1, 1'b1, 16'hFEFF, 16'hFEFF, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 16'h1234, 16'h1234, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 16'h5678, C_EAV,   1'b1};
        tbl[14] = '{1'b0, 1'b0, 16'h0000, C_TRAIN, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 16'hAAAA, C_TRAIN, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 16'h0000, C_TRAIN, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 16'h0000, C_TRAIN, 1'b0};

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset lanes", {30'd0, ov_lane}, 32'd3);
        check("reset ready/sync/fclk", {29'd0, o_ready, o_sync, o_frame_clk}, 32'd1);
        reset = 1'b0;

        repeat (8) send_word(1'b0, 1'b0, 16'h0000, 1'b0);

        // Entry i is the current word of the load two word periods later.
        base = rx_q.size();
        for (int i = 0; i < 18; i++) send_word(tbl[i].v, tbl[i].h, tbl[i].d, 1'b0);
        repeat (3) send_word(1'b0, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 18; i++) begin
            if (rx_q.size() > base + 2 + i)
                check($sformatf("tbl[%0d] {sync,word}", i),
                      {15'd0, rx_q[base + 2 + i]}, {15'd0, tbl[i].es, tbl[i].exp});
            else
                check($sformatf("tbl[%0d] captured", i), 32'd0, 32'd1);
        end

        // Abort a pixel word at cnt==3.
        send_word(1'b1, 1'b0, 16'h0000, 1'b0);
        send_word(1'b1, 1'b1, 16'h1357, 1'b0);
        send_word(1'b1, 1'b1, 16'h2468, 1'b0);
        send_word(1'b1, 1'b1, 16'h7BDF, 1'b0);
        i_href = 1'b1; iv_data = 16'h0F0F;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset lanes", {30'd0, ov_lane}, 32'd3);
        check("midreset fclk/sync", {30'd0, o_frame_clk, o_sync}, 32'd2);
        @(negedge clk);
        reset = 1'b0;
        i_vref = 1'b0; i_href = 1'b0; iv_data = 16'h0000;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check($sformatf("post-reset ready k=%0d", k), {31'd0, o_ready}, {31'd0, (k == 7)});
        end
        @(negedge clk);

        fv = 1'b1;
        for (int w = 0; w < 300; w++) begin
            logic        h;
            logic [15:0] d;
            if ($urandom_range(0, 99) < 8) fv = ~fv;
            h = ($urandom_range(0, 99) < 60);
            d = $urandom_range(0, 65535);
            if ($urandom_range(0, 3) == 0) d = {8'hFF, d[7:0]};
            send_word(fv, h, d, ($urandom_range(0, 3) == 0));
        end
        repeat (3) send_word(1'b0, 1'b0, 16'h0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ccd_data_serializer.md
# ccd_data_serializer

Transmit-side counterpart of the CCD data deserializer. Takes the parallel 16-bit pixel stream with `i_vref`/`i_href` framing and serializes it onto two single-bit lanes, MSB first, with a word-aligned frame clock. Blanking carries a bitslip training pattern, and reserved sync words mark line start and end. Used as the AFE-side source in deserializer loopback benches and as the serial output stage of the image link.

## Interface
Parameters:
- `TRAIN_WORD`, 16'hF0F0: word sent during blanking; each lane sees 8'hF0, the bitslip pattern.
- `SAV_WORD`, 16'hFF00: start-of-active-line word.
- `EAV_WORD`, 16'hFF80: end-of-active-line word.
- `PIX_MAX`, 16'hFEFF: pixel clip ceiling. Upper byte 8'hFF is reserved for sync words.

Ports:
- `clk`  in  1: single clock, both bit rate and logic clock.
- `reset`  in  1: synchronous, active-high.
- `i_vref`  in  1: frame valid.
- `i_href`  in  1: line valid.
- `iv_data`  in  16: pixel word.
- `o_ready`  out  1: word strobe. Inputs are sampled on the rising edge where `o_ready`=1.
- `ov_lane`  out  2: serial lanes. Lane 0 carries word bits [7:0]; lane 1 carries word bits [15:8]; MSB first.
- `o_frame_clk`  out  1: word-aligned frame clock, high during bit slots 0–3 of each word.
- `o_sync`  out  1: high for the 8 cycles a SAV or EAV word is on the lanes.

## Operation
- **Bit counter** `cnt` (3 bits) runs 0..7 and wraps. Slot 0 is the MSB. `o_ready` = (`cnt`==7), registered so it is high during the cycle where `cnt`==7.
- **Word boundary:** the rising edge at `cnt`==7.
- **Sampling:** at a boundary, sample `a_in`=`i_vref`&`i_href` and `d_in`=`iv_data`.
- **Two-stage look-around pipe.** Registers `n` = {active, data} and `c_act`.
- **Load at each boundary.** `sreg` loads `enc(n, a_in, c_act)`, then `c_act<=n.active` and `n<={a_in,d_in}`.
- **Encoder** `enc(cur, next_act, prev_act)`, in priority order:
  - cur.active → min(cur.data, `PIX_MAX`);
  - else next_act → `SAV_WORD`. A single blank word between two lines sends SAV, not EAV.
  - else prev_act → `EAV_WORD`;
  - else → `TRAIN_WORD`.
- **Shift:** on non-boundary edges, `sreg` shifts left by one within each byte.
- **Lanes:** `ov_lane[0]`=`sreg`[7], `ov_lane[1]`=`sreg`[15]. Both are register bits, so there is no combinational path from the inputs.
- **Sync flag:** `o_sync` is registered alongside the `sreg` load and is 1 iff the encoder selected SAV or EAV.
- **Framing:**
  - `i_vref`=0 forces inactive regardless of `i_href`, so the lanes carry `TRAIN_WORD` throughout frame blanking apart from the EAV word that closes the last line.
  - `i_href` may toggle only at word boundaries. Mid-word changes are ignored; only the sampled value counts.
- **Reset values:**
  - `cnt`=0, so `o_frame_clk`=1.
  - `sreg`=`TRAIN_WORD`, so `ov_lane`=2'b11.
  - `n`={0,0}, `c_act`=0.
  - `o_ready`=0, `o_sync`=0.
- **Reset asserted mid-word:** the current word is aborted. Output returns to the reset state on the next edge, and the first boundary occurs 8 cycles after reset deasserts.

## Timing
- **Cadence:** one pixel every 8 clocks. Throughput is clk/8 words.
- **Latency:** a word sampled at boundary edge T is loaded at boundary T+8. Its MSB is on the lanes in the cycle after edge T+8; its LSB is on the lanes after edge T+15.
- **Line markers:**
  - SAV occupies the 8 cycles immediately before the first pixel.
  - EAV occupies the 8 cycles immediately after the last pixel.
  - Both are word-aligned to `o_frame_clk`.
- **Frame clock:** `o_frame_clk` rises at the MSB slot of every word. Its period is 8 clocks at 50% duty, continuous from reset.
- **Back-pressure:** none; upstream must present data on every `o_ready`.

## Test plan
- **Reset/idle:** hold `i_vref`=0 for 64 clocks → each lane repeats 1111_0000, `o_frame_clk` is high on the 1-slots, `o_sync`=0, `o_ready` pulses every 8th cycle.
- **Single line:** `vref`=1; `href`=1 for 4 words with data 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF → lanes carry TRAIN, SAV(FF00), the 4 pixels, EAV(FF80), then TRAIN. Lane1 serial for 16'h0123 is 00000001 and lane0 is 00100011. First pixel MSB appears 8 clocks after its sample edge.
- **Clipping:** active data 16'hFFFF and 16'hFF00 → both transmitted as 16'hFEFF. Data 16'hFEFF passes unchanged.
- **One-word gap between lines:** `href` pattern 1,1,0,1,1 → the gap word is SAV, there is no EAV between the lines, and EAV follows the final pixel.
- **Vref drop with href high:** `i_vref` falls while `i_href`=1 → the next word is EAV, followed by TRAIN.
- **Mid-word reset:** assert `reset` at `cnt`=3 during a pixel → next cycle `ov_lane`=2'b11, `o_frame_clk`=1, `o_sync`=0. The first `o_ready` comes 8 cycles after release, and TRAIN then resumes with correct alignment.
